// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, redirect handling and a
// single-entry instruction holding register toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] pc,
  output logic [31:0] instr_count,
  output logic        misalign_err
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            mis_q, mis_d;
  logic            req_q, hold_q;
  logic [XLEN-1:0] target;

  assign target = {redirect_pc[XLEN-1:2], 2'b00};

  // Next state and datapath; a redirect outside IDLE always wins over pc+4.
  always_comb begin
    state_d = state;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;

    if (redirect && (state != S_IDLE)) begin
      pc_d = target;
      if (redirect_pc[1:0] != 2'b00) mis_d = 1'b1;
    end

    case (state)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) state_d = redirect ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          state_d = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          ifpc_d  = pc_q;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d = S_REQ;
        end else if (if_ready) begin
          pc_d    = pc_q + XLEN'(4);
          cnt_d   = cnt_q + XLEN'(1);
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; handshake flags are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ifpc_q  <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      req_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state   <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      req_q   <= (state_d == S_REQ);
      hold_q  <= (state_d == S_HOLD);
    end
  end

  assign imem_req_valid = req_q;
  assign imem_addr      = pc_q;
  assign if_valid       = hold_q;
  assign if_instr       = instr_q;
  assign if_pc          = ifpc_q;
  assign pc             = pc_q;
  assign instr_count    = cnt_q;
  assign misalign_err   = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic,
// checked against an architectural model of the fetch stream and a simple memory.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] pc;
  logic [31:0] instr_count;
  logic        misalign_err;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .pc             (pc),
    .instr_count    (instr_count),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents; address 0 holds 32'h0000_0013.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Architectural model: fetch pc, delivered count, sticky misalign.
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  logic        exp_mis;
  int          since_rst;
  // Memory model: at most one pending response.
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat_min = 0;
  int          lat_max = 0;
  // Hold-stability tracking and delivery log.
  logic        hold_prev;
  logic [31:0] hold_pc, hold_instr;
  int          cyc = 0;
  int          last_del_cyc = 0;
  int          gap = 0;
  logic        delivered;
  int          n_del = 0;
  logic [31:0] del_pcs[$];

  task automatic check_reset_outputs();
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("rst_pc", pc, RST_PC);
    check_eq("rst_imem_addr", imem_addr, RST_PC);
    check_eq("rst_if_instr", if_instr, 32'd0);
    check_eq("rst_if_pc", if_pc, 32'd0);
    check_eq("rst_instr_count", instr_count, 32'd0);
    check_eq("rst_misalign", 32'(misalign_err), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect = 1'b0;
    imem_req_ready = 1'b0;
    if_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    #1;
    check_reset_outputs();
    exp_pc = RST_PC;
    exp_cnt = '0;
    exp_mis = 1'b0;
    mem_pend = 1'b0;
    hold_prev = 1'b0;
    since_rst = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: check state, drive inputs, advance the model, return at the next negedge.
  task automatic step(input logic rd, input logic [31:0] rpc, input logic mrdy, input logic ird);
    logic rsp_v, acc, rd_eff;
    check_eq("pc", pc, exp_pc);
    check_eq("instr_count", instr_count, exp_cnt);
    check_eq("misalign_err", 32'(misalign_err), 32'(exp_mis));
    if (hold_prev) begin
      check_eq("hold_valid", 32'(if_valid), 32'd1);
      check_eq("hold_pc", if_pc, hold_pc);
      check_eq("hold_instr", if_instr, hold_instr);
    end
    rsp_v = mem_pend && (mem_cnt == 0);
    redirect = rd;
    redirect_pc = rpc;
    imem_req_ready = mrdy;
    if_ready = ird;
    imem_rsp_valid = rsp_v;
    imem_rsp_data = rsp_v ? mem_word(mem_addr) : $urandom;
    rd_eff = rd && (since_rst > 0);
    acc = imem_req_valid && mrdy;
    if (acc && !rd_eff) check_eq("req_addr", imem_addr, exp_pc);
    if (acc) check_eq("one_outstanding", 32'(mem_pend && !rsp_v), 32'd0);
    delivered = if_valid && ird && !rd_eff;
    if (delivered) begin
      check_eq("deliver_pc", if_pc, exp_pc);
      check_eq("deliver_instr", if_instr, mem_word(exp_pc));
      del_pcs.push_back(if_pc);
      gap = cyc - last_del_cyc;
      last_del_cyc = cyc;
      n_del++;
      exp_pc = exp_pc + 32'd4;
      exp_cnt = exp_cnt + 32'd1;
    end
    hold_prev = if_valid && !ird && !rd_eff;
    hold_pc = if_pc;
    hold_instr = if_instr;
    if (rd_eff) begin
      exp_pc = {rpc[31:2], 2'b00};
      if (rpc[1:0] != 2'b00) exp_mis = 1'b1;
    end
    if (rsp_v) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (acc) begin
      mem_pend = 1'b1;
      mem_addr = imem_addr;
      mem_cnt = int'($urandom_range(lat_max, lat_min));
    end
    @(posedge clk);
    since_rst++;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic        found;
    logic [31:0] cnt_before, r, rpc;
    int          del_start;

    @(negedge clk);
    do_reset();

    // Straight-line fetch, 1-cycle memory, decode always ready.
    lat_min = 0; lat_max = 0;
    del_pcs.delete();
    for (int i = 0; i < 13; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      if (delivered && del_pcs.size() > 1) check_eq("throughput_gap", 32'(gap), 32'd3);
    end
    check_eq("straight_count", instr_count, 32'd4);
    check_eq("straight_ndel", 32'(del_pcs.size()), 32'd4);
    foreach (del_pcs[i]) check_eq("straight_pc", del_pcs[i], 32'(i * 4));

    // Backpressure in HOLD for 5 cycles.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (if_valid) found = 1'b1;
      else step(1'b0, '0, 1'b1, 1'b0);
    end
    check_eq("bp_reach_hold", 32'(found), 32'd1);
    check_eq("bp_instr", if_instr, 32'h0000_0013);
    check_eq("bp_if_pc", if_pc, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_no_req", 32'(imem_req_valid), 32'd0);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("bp_next_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("bp_next_req_addr", imem_addr, 32'd4);

    // Redirect while waiting for the response to addr 8.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req_valid && imem_addr == 32'd8) found = 1'b1;
      step(1'b0, '0, 1'b1, 1'b1);
    end
    check_eq("rw_req8_seen", 32'(found), 32'd1);
    step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !imem_req_valid; i++) step(1'b0, '0, 1'b0, 1'b1);
    check_eq("rw_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("rw_req_addr", imem_addr, 32'h0000_0100);
    check_eq("rw_count", instr_count, 32'd2);

    // Redirect in HOLD with simultaneous if_ready.
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 20 && !if_valid; i++) step(1'b0, '0, 1'b1, 1'b0);
    check_eq("rh_reach_hold", 32'(if_valid), 32'd1);
    cnt_before = instr_count;
    step(1'b1, 32'h0000_0040, 1'b1, 1'b1);
    check_eq("rh_count", instr_count, cnt_before);
    check_eq("rh_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("rh_req_addr", imem_addr, 32'h0000_0040);

    // Misaligned redirect target; flag is sticky.
    step(1'b1, 32'h0000_0206, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !imem_req_valid; i++) step(1'b0, '0, 1'b1, 1'b1);
    check_eq("mis_req_addr", imem_addr, 32'h0000_0204);
    check_eq("mis_flag", 32'(misalign_err), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1);
    check_eq("mis_sticky", 32'(misalign_err), 32'd1);

    // pc wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !if_valid; i++) step(1'b0, '0, 1'b1, 1'b0);
    check_eq("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("wrap_req_addr", imem_addr, 32'h0000_0000);

    // Asynchronous reset in the middle of WAIT with pc=0x20.
    do_reset();
    lat_min = 5; lat_max = 5;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0020, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("ar_pc_before", pc, 32'h0000_0020);
    check_eq("ar_wait_no_req", 32'(imem_req_valid), 32'd0);
    #2;
    do_reset();
    check_eq("ar_idle_no_req", 32'(imem_req_valid), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    check_eq("ar_first_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("ar_first_req_addr", imem_addr, RST_PC);

    // Random traffic against the model.
    do_reset();
    lat_min = 0; lat_max = 3;
    del_start = n_del;
    for (int i = 0; i < 2500; i++) begin
      r = $urandom;
      rpc = {20'h0, r[11:2], (r[31:30] == 2'b00) ? r[1:0] : 2'b00};
      step(($urandom_range(0, 9) == 0), rpc, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
    end
    check_eq("rand_progress", 32'((n_del - del_start) > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
